// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle control sequencer for the MIPS datapath (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Define MIPS_CTRL_PERF_CNT_EN to add the retired-instruction counter and instr_count port.
module mips_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        byte_en,
  output logic        halfword_en,
  output logic        word_en,
  output logic        reg_write,
  output logic        reg_dst_rt,
  output logic        pc_en,
  output logic        branch_taken,
  output logic        jump_taken,
  output logic        halted
`ifdef MIPS_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam int WW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_WAIT_MAX - 1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_ALU, C_IMM, C_LOAD, C_STORE, C_BR, C_J, C_ILL} cls_t;

  state_t         state_q, state_d;
  logic [31:0]    ir_q, ir_d;
  logic [WW-1:0]  wait_q, wait_d;

  cls_t           cls;
  logic [2:0]     op;
  logic [2:0]     size;   // {byte, halfword, word}
  logic           is_nop;
  logic [5:0]     opc, funct;

  assign opc    = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign is_nop = (ir_q == 32'h0);

  // Instruction classification from the latched IR
  always_comb begin
    cls  = C_ILL;
    op   = 3'b000;
    size = 3'b000;
    case (opc)
      6'h00: begin
        cls = C_ALU;
        case (funct)
          6'h20: op = 3'b000;
          6'h22: op = 3'b001;
          6'h24: op = 3'b010;
          6'h25: op = 3'b011;
          6'h26: op = 3'b101;
          6'h2A: op = 3'b111;
          default: if (!is_nop) cls = C_ILL;
        endcase
      end
      6'h08: cls = C_IMM;
      6'h0C: begin cls = C_IMM; op = 3'b010; end
      6'h0D: begin cls = C_IMM; op = 3'b011; end
      6'h23: begin cls = C_LOAD;  size = 3'b001; end
      6'h25: begin cls = C_LOAD;  size = 3'b010; end
      6'h24: begin cls = C_LOAD;  size = 3'b100; end
      6'h2B: begin cls = C_STORE; size = 3'b001; end
      6'h29: begin cls = C_STORE; size = 3'b010; end
      6'h28: begin cls = C_STORE; size = 3'b100; end
      6'h04, 6'h05: begin cls = C_BR; op = 3'b001; end
      6'h02: cls = C_J;
      default: cls = C_ILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 32'h0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = (cls == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_ALU, C_IMM:   state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // the access gets at most MEM_WAIT_MAX MEM cycles before it is abandoned
        if (mem_ready)               state_d = (cls == C_LOAD) ? S_WB : S_FETCH;
        else if (wait_q == WAIT_LAST) state_d = S_HALT;
        else                          wait_d  = wait_q + 1'b1;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    alu_op       = 3'b000;
    alu_src_imm  = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    byte_en      = 1'b0;
    halfword_en  = 1'b0;
    word_en      = 1'b0;
    reg_write    = 1'b0;
    reg_dst_rt   = 1'b0;
    pc_en        = 1'b0;
    branch_taken = 1'b0;
    jump_taken   = 1'b0;
    halted       = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op      = op;
      alu_src_imm = (cls == C_IMM) || (cls == C_LOAD) || (cls == C_STORE);
      reg_dst_rt  = (cls == C_IMM) || (cls == C_LOAD);
    end
    case (state_q)
      S_EXEC: begin
        if (cls == C_BR) begin
          pc_en        = 1'b1;
          branch_taken = opc[0] ? ~zero_flag : zero_flag;
        end else if (cls == C_J) begin
          pc_en      = 1'b1;
          jump_taken = 1'b1;
        end
      end
      S_MEM: begin
        mem_read                        = (cls == C_LOAD);
        mem_write                       = (cls == C_STORE);
        {byte_en, halfword_en, word_en} = size;
        pc_en                           = (cls == C_STORE) && mem_ready;
      end
      S_WB: begin
        reg_write = !is_nop;
        pc_en     = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt_q <= 32'h0;
    else if (pc_en) cnt_q <= cnt_q + 32'h1;
  end
  assign instr_count = cnt_q;
`endif

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Randomized bench for mips_ctrl_fsm against a per-instruction behavioural model.
module tb_mips_ctrl_fsm;
  localparam int WMAX = 15;
  localparam int K_ALU = 0, K_IMM = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_J = 5, K_ILL = 6;
  localparam logic [5:0] FUNCTS [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
  localparam logic [2:0] FOPS   [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};

  typedef struct packed {
    logic [2:0] alu_op;
    logic src, mrd, mwr, be, he, we, rw, rdt, pc, bt, jt, hlt;
  } ovec_t;

  typedef struct {
    int cls; logic [2:0] op; logic imm, rdt, nop, bne; logic [2:0] sz;
  } attr_t;

  logic clk = 1'b0, reset = 1'b1, zero_flag = 1'b0, mem_ready = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [2:0] alu_op;
  logic alu_src_imm, mem_read, mem_write, byte_en, halfword_en, word_en;
  logic reg_write, reg_dst_rt, pc_en, branch_taken, jump_taken, halted;
`ifdef MIPS_CTRL_PERF_CNT_EN
  logic [31:0] instr_count;
`endif

  mips_ctrl_fsm #(.MEM_WAIT_MAX(WMAX)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero_flag(zero_flag), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .mem_read(mem_read), .mem_write(mem_write),
    .byte_en(byte_en), .halfword_en(halfword_en), .word_en(word_en), .reg_write(reg_write),
    .reg_dst_rt(reg_dst_rt), .pc_en(pc_en), .branch_taken(branch_taken),
    .jump_taken(jump_taken), .halted(halted)
`ifdef MIPS_CTRL_PERF_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  ovec_t dut_v, exp_v;
  assign dut_v = {alu_op, alu_src_imm, mem_read, mem_write, byte_en, halfword_en, word_en,
                  reg_write, reg_dst_rt, pc_en, branch_taken, jump_taken, halted};

  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_pc_cyc = -1, pc_pulses = 0, halt_first = -1, force_zf = -1;
  logic last_bt = 1'b0;
  logic [31:0] exp_cnt = 0;
  logic chk_en = 1'b0;
  string phase = "reset";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk({phase, "/outs"}, 32'(dut_v), 32'(exp_v));
`ifdef MIPS_CTRL_PERF_CNT_EN
    chk({phase, "/cnt"}, instr_count, exp_cnt);
`endif
    if (pc_en) begin pc_pulses++; last_pc_cyc = cyc; last_bt = branch_taken; end
    if (halted && halt_first < 0) halt_first = cyc;
  end

  function automatic attr_t model(input logic [31:0] w);
    attr_t a;
    a.cls = K_ILL; a.op = 3'd0; a.imm = 0; a.rdt = 0; a.nop = (w == 32'h0); a.bne = 0; a.sz = 3'b000;
    if (w[31:26] == 6'h00) begin
      if (a.nop) a.cls = K_ALU;
      for (int i = 0; i < 6; i++) if (w[5:0] == FUNCTS[i]) begin a.cls = K_ALU; a.op = FOPS[i]; end
    end else begin
      case (w[31:26])
        6'h08: begin a.cls = K_IMM; a.imm = 1; a.rdt = 1; end
        6'h0C: begin a.cls = K_IMM; a.imm = 1; a.rdt = 1; a.op = 3'd2; end
        6'h0D: begin a.cls = K_IMM; a.imm = 1; a.rdt = 1; a.op = 3'd3; end
        6'h23: begin a.cls = K_LD; a.imm = 1; a.rdt = 1; a.sz = 3'b001; end
        6'h25: begin a.cls = K_LD; a.imm = 1; a.rdt = 1; a.sz = 3'b010; end
        6'h24: begin a.cls = K_LD; a.imm = 1; a.rdt = 1; a.sz = 3'b100; end
        6'h2B: begin a.cls = K_ST; a.imm = 1; a.sz = 3'b001; end
        6'h29: begin a.cls = K_ST; a.imm = 1; a.sz = 3'b010; end
        6'h28: begin a.cls = K_ST; a.imm = 1; a.sz = 3'b100; end
        6'h04: begin a.cls = K_BR; a.op = 3'd1; end
        6'h05: begin a.cls = K_BR; a.op = 3'd1; a.bne = 1; end
        6'h02: a.cls = K_J;
        default: ;
      endcase
    end
    return a;
  endfunction

  task automatic step(input ovec_t e);
    exp_v = e; chk_en = 1'b1;
    @(posedge clk); #1;
    if (e.pc) exp_cnt++;
    cyc++;
  endtask

  task automatic side();
    zero_flag = 1'($urandom); mem_ready = 1'($urandom); instr = $urandom;
  endtask

  task automatic halt_for(input int n);
    ovec_t e;
    for (int i = 0; i < n; i++) begin side(); e = '0; e.hlt = 1'b1; step(e); end
  endtask

  task automatic do_reset();
    side(); reset = 1'b1; exp_cnt = 0; halt_first = -1;
    step('0);
    reset = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; W = not-ready MEM cycles before mem_ready
  task automatic run_instr(input logic [31:0] w, input int W, output int cyc0, output logic hlt);
    attr_t a;
    ovec_t b, e;
    logic rdy;
    a = model(w); cyc0 = cyc; hlt = 1'b0;
    side(); instr = w; step('0);
    side(); step('0);
    if (a.cls == K_ILL) begin halt_for(20); hlt = 1'b1; return; end
    b = '0;
    b.alu_op = a.op; b.src = a.imm; b.rdt = a.rdt;
    side();
    if (force_zf >= 0) zero_flag = force_zf[0];
    e = b;
    if (a.cls == K_BR) begin e.pc = 1'b1; e.bt = a.bne ? ~zero_flag : zero_flag; end
    if (a.cls == K_J)  begin e.pc = 1'b1; e.jt = 1'b1; end
    step(e);
    if (a.cls == K_LD || a.cls == K_ST) begin
      rdy = 1'b0;
      for (int k = 0; k < WMAX && !rdy; k++) begin
        side(); mem_ready = (k == W); rdy = mem_ready;
        e = b; e.mrd = (a.cls == K_LD); e.mwr = (a.cls == K_ST);
        {e.be, e.he, e.we} = a.sz; e.pc = (a.cls == K_ST) && rdy;
        step(e);
      end
      if (!rdy) begin halt_for(20); hlt = 1'b1; return; end
    end
    if (a.cls == K_ALU || a.cls == K_IMM || a.cls == K_LD) begin
      side(); e = b; e.rw = !a.nop; e.pc = 1'b1; step(e);
    end
  endtask

  function automatic logic [31:0] gen(input int k);
    logic [31:0] w;
    logic [5:0] opcs [9] = '{6'h08, 6'h0C, 6'h0D, 6'h23, 6'h25, 6'h24, 6'h2B, 6'h29, 6'h28};
    w = $urandom;
    case (k)
      0, 1: begin w[31:26] = 6'h00; w[5:0] = FUNCTS[$urandom_range(0, 5)]; end
      2:    w = 32'h0;
      3, 4, 5, 6: w[31:26] = opcs[$urandom_range(0, 8)];
      7:    w[31:26] = ($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05;
      8:    w[31:26] = 6'h02;
      default: begin w[31:26] = 6'h00; w[5:0] = 6'h00; w[11] = 1'b1; end
    endcase
    return w;
  endfunction

  initial begin
    int c0, p0, wt;
    logic h;
    repeat (2) @(posedge clk);
    #1;
    step('0);
    reset = 1'b0;

    phase = "addi";
    p0 = pc_pulses;
    run_instr(32'h20020005, 0, c0, h);
    chk("addi_cpi", 32'(last_pc_cyc - c0 + 1), 32'd4);
    chk("addi_pulses", 32'(pc_pulses - p0), 32'd1);

    phase = "beq_z1"; force_zf = 1;
    run_instr(32'h10430002, 0, c0, h);
    chk("beq_cpi", 32'(last_pc_cyc - c0 + 1), 32'd3);
    chk("beq_z1_taken", 32'(last_bt), 32'd1);
    phase = "beq_z0"; force_zf = 0;
    run_instr(32'h10430002, 0, c0, h);
    chk("beq_z0_taken", 32'(last_bt), 32'd0);
    force_zf = -1;

    phase = "lw";
    run_instr(32'h8C220000, 2, c0, h);
    chk("lw_cpi", 32'(last_pc_cyc - c0 + 1), 32'd7);

    phase = "sb_timeout";
    p0 = pc_pulses;
    run_instr(32'hA0230004, WMAX, c0, h);
    chk("sb_halted", 32'(halted), 32'd1);
    chk("sb_no_pc", 32'(pc_pulses - p0), 32'd0);
    do_reset();

    phase = "illegal";
    run_instr(32'hFC000000, 0, c0, h);
    chk("ill_halt_c3", 32'(halt_first - c0 + 1), 32'd3);
    do_reset();
    phase = "nop";
    run_instr(32'h0, 0, c0, h);
    chk("nop_cpi", 32'(last_pc_cyc - c0 + 1), 32'd4);

    phase = "rst_mid";
    p0 = pc_pulses;
    side(); instr = 32'h20020005; step('0);
    side(); step('0);
    do_reset();
    chk("rst_mid_no_pc", 32'(pc_pulses - p0), 32'd0);

`ifdef MIPS_CTRL_PERF_CNT_EN
    phase = "cnt";
    do_reset();
    for (int i = 0; i < 3; i++) run_instr(32'h0, 0, c0, h);
    run_instr(32'h08000010, 0, c0, h);
    chk("cnt_four", instr_count, 32'd4);
    for (int i = 0; i < 3; i++) run_instr(32'h0, 0, c0, h);
    p0 = pc_pulses;
    side(); instr = 32'h08000010; step('0);
    side(); step('0);
    do_reset();
    chk("cnt_rst_zero", instr_count, 32'd0);
    chk("cnt_rst_no_jump", 32'(pc_pulses - p0), 32'd0);
`endif

    phase = "random";
    for (int i = 0; i < 120; i++) begin
      wt = ($urandom_range(0, 11) == 0) ? WMAX : $urandom_range(0, 4);
      run_instr(gen($urandom_range(0, 9)), wt, c0, h);
      if (h) do_reset();
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_ctrl_fsm.md
# mips_ctrl_fsm

Multi-cycle control sequencer for the MIPS datapath. It latches each fetched instruction, decodes it, and steps through FETCH/DECODE/EXEC/MEM/WB states. In each state it drives the datapath control strobes: ALU op, memory read/write, access-size enables, register write, PC advance, branch and jump select. It sits beside the datapath and is the only source of its control inputs; the PC advances only when this block asserts `pc_en`.

## Interface
Parameters:
- `MEM_WAIT_MAX`, 15: cycles MEM may wait on `mem_ready` before the access is abandoned and the FSM halts.

Ports:
- `clk`  in  1  — system clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-high; returns the FSM to FETCH with all outputs 0.
- `instr`  in  32  — instruction currently presented by instruction memory.
- `zero_flag`  in  1  — ALU zero flag from the datapath.
- `mem_ready`  in  1  — data memory access complete; sampled in MEM only.
- `alu_op`  out  3  — ALU operation code: 000 add, 001 sub, 010 and, 011 or, 101 xor, 111 slt.
- `alu_src_imm`  out  1  — 1 selects the sign-extended immediate as ALU operand B.
- `mem_read`, `mem_write`  out  1 each  — data memory strobes.
- `byte_en`, `halfword_en`, `word_en`  out  1 each  — access size; one-hot, or all 0.
- `reg_write`  out  1  — register file write enable.
- `reg_dst_rt`  out  1  — 1 writes to `rt`, 0 writes to `rd`.
- `pc_en`  out  1  — PC update strobe; high for exactly one cycle per retired instruction.
- `branch_taken`, `jump_taken`  out  1 each  — PC source select; valid only while `pc_en`=1.
- `halted`  out  1  — sticky; set on an illegal opcode or a MEM timeout.
- `instr_count`  out  32  — retired-instruction count; present only with `MIPS_CTRL_PERF_CNT_EN`.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free, but HALT must be distinct.
- FETCH: latch `instr` into the internal IR, then go to DECODE.
- DECODE: classify the IR opcode. An illegal opcode goes to HALT; anything else goes to EXEC.
- Legal opcodes:
  - R-type (000000) with funct add/sub/and/or/xor/slt (0x20/0x22/0x24/0x25/0x26/0x2A). Any other funct is illegal.
  - addi 0x08, andi 0x0C, ori 0x0D.
  - lw 0x23, lhu 0x25, lbu 0x24.
  - sw 0x2B, sh 0x29, sb 0x28.
  - beq 0x04, bne 0x05, j 0x02.
  - The all-zero word is a NOP: treat it as R-type, but `reg_write` stays 0.
- EXEC:
  - `alu_op` is held from EXEC through WB.
  - ALU and immediate instructions: go to WB.
  - Loads and stores: `alu_op`=000, `alu_src_imm`=1, then go to MEM.
  - beq/bne: `alu_op`=001. Assert `pc_en`, with `branch_taken` = `zero_flag` for beq or ~`zero_flag` for bne. Return to FETCH.
  - j: `pc_en`=1, `jump_taken`=1. Return to FETCH.
- MEM:
  - Assert `mem_read` or `mem_write` and the size enable: word for lw/sw, halfword for lhu/sh, byte for lbu/sb.
  - Stay in MEM until `mem_ready`=1.
  - On `mem_ready`: a load goes to WB; a store asserts `pc_en` and returns to FETCH.
  - The wait counter saturates at `MEM_WAIT_MAX`. On reaching it, go to HALT with no `pc_en`.
- WB: `reg_write`=1 except for NOP; `pc_en`=1; return to FETCH.
- HALT: every strobe is 0 and `halted`=1. Only `reset` leaves HALT.
- At most one of `branch_taken`/`jump_taken` is ever high. `mem_read` and `mem_write` are never both high.

## Timing
- Reset: the state is FETCH and every output is 0, including `instr_count`. Reset asserted mid-instruction aborts it, with no `pc_en` and no `reg_write` pulse.
- Outputs are Moore-decoded from the registered state and IR. The exception is the branch select, which uses `zero_flag` combinationally in EXEC.
- Cycles per instruction, counted from FETCH through the `pc_en` cycle inclusive:
  - ALU/immediate: 4.
  - Load: 5 + wait cycles.
  - Store: 4 + wait cycles.
  - beq/bne/j: 3.
- `mem_ready` high on the first MEM cycle means zero wait cycles.
- `mem_ready` is ignored outside MEM.

## Configuration
- `MIPS_CTRL_PERF_CNT_EN` defined:
  - Adds the `instr_count` port and counter.
  - The counter increments on every `pc_en` cycle.
  - It wraps from 0xFFFFFFFF to 0 and freezes in HALT.
- Undefined: there is no port and no counter logic.

## Test plan
- addi $2,$0,5 (0x20020005) after reset:
  - FETCH→DECODE→EXEC→WB.
  - `alu_op`=000, `alu_src_imm`=1, `reg_dst_rt`=1.
  - `reg_write` and `pc_en` high on cycle 4 only.
- beq with `zero_flag`=1 (0x10430002): `pc_en` and `branch_taken`=1 on cycle 3. Repeat with `zero_flag`=0: `branch_taken`=0, `pc_en`=1.
- lw (0x8C220000) with `mem_ready` delayed 2 cycles:
  - `mem_read` and `word_en` high for 3 MEM cycles.
  - `reg_write` and `pc_en` on cycle 7.
- sb (0xA0230004) with `mem_ready` held 0: after `MEM_WAIT_MAX`=15 cycles, `halted`=1, all strobes 0, no `pc_en`.
- Illegal opcode 0xFC000000:
  - HALT at cycle 3; `halted` stays 1 for 20 cycles.
  - Asserting `reset` clears it, and a following NOP retires in 4 cycles.
- With `MIPS_CTRL_PERF_CNT_EN`: 3 NOPs then a j → `instr_count`=4. Reset asserted during the j's EXEC → count 0 and no `jump_taken`.
